mdc_stage5: RTL and testbench
=============================

# mdc_stage5

Final radix-2 butterfly stage of the 32-point MDC FFT. Consumes the two parallel lanes from stage 4 (16 pair-cycles per frame) and forms the distance-1 butterflies with trivial twiddle (W^0). Emits one output pair per cycle plus a one-cycle start pulse in exactly the format the downstream bit-reversal ping-pong buffer expects: pulse one cycle before the first pair, then 16 consecutive pairs.

## Interface
- DW, 9: sample width, signed two's complement, per re/im component
- FRAME_PAIRS, 16: pair-cycles per frame (N/2)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- valid_in  in  1  one-cycle pulse; marks the cycle carrying pair k=0 of a frame
- state4_outUp_re / _im  in  DW  lane U sample U_k, signed
- state4_outL_re / _im  in  DW  lane L sample L_k, signed
- valid_ping_pong_in  out  1  one-cycle frame-start pulse to the ping-pong buffer
- state5_outUp_re / _im  out  DW  output pair, first element
- state5_outL_re / _im  out  DW  output pair, second element

## Operation
- Input FSM: IDLE, RUN. IDLE + valid_in -> RUN, in_cnt=0. RUN: in_cnt increments each cycle. in_cnt==15 -> IDLE, unless valid_in is high in that cycle, in which case stay in RUN with in_cnt=0 (back-to-back frames). valid_in while RUN with in_cnt<15 is ignored.
- Even k: latch U_k, L_k into hold registers.
- Odd k: butterfly each lane against its hold: U-butterfly (U_{k-1}, U_k) and L-butterfly (L_{k-1}, L_k), applied independently to re and im.
- Butterfly with a=earlier sample, b=later sample: sum=(a+b)>>>1, diff=(a-b)>>>1, computed at DW+1 bits, arithmetic shift (floor), result fits DW exactly; no saturation logic.
- Output order per input pair (k-1,k): first (Up=U-sum, L=U-diff), next cycle (Up=L-sum, L=L-diff). L results held one cycle in a skid register.
- Output pair j (0..15) = butterfly of inputs {2⌊j/2⌋, 2⌊j/2⌋+1}, lane U for even j, lane L for odd j.
- Data outputs are 0 whenever no output pair is valid.

## Timing
- Frame with valid_in at cycle T: valid_ping_pong_in high at T+1 only; output pair j registered and visible during T+2+j, j=0..15.
- Latency: first input to first output = 2 cycles; throughput 1 pair/cycle, continuous.
- Back-to-back frames (next valid_in at T+16): pulse at T+17, new pairs from T+18; previous frame's last pair at T+17; no gap, no overlap. The downstream buffer needs ≥1 idle cycle between frames; that is a system scheduling rule, not enforced here.
- Reset: at the rising edge with rst_n=0, FSM -> IDLE, counters, holds and skid register -> 0, all outputs -> 0 from that edge; an in-flight frame is discarded, with no partial pulse or data afterwards.
- valid_in asserted in the same cycle rst_n is deasserted is accepted.

## Structure
- Shared package fft_pkg: DW=9, N=32, FRAME_PAIRS=N/2, signed sample typedef, complex {re,im} struct typedef.
- One sub-module: bfly2_scale, a combinational (a,b) -> ((a+b)>>>1, (a-b)>>>1) for one complex pair. Instantiated twice (U lane, L lane); the top holds FSM, counters, hold, skid and output registers.

## Test plan
- Single frame, U0=100+j0, U1=20+j0, all else 0, valid_in at T -> pulse at T+1; pair at T+2 = (60, 40); pair at T+3 = (0, 0); pulses only once.
- Extremes: L0=255, L1=-256 (re and im) -> pair at T+3 = (Up=-1, L=255); L0=-256, L1=255 -> (-1, -256); no wrap.
- Ramp U_k=k, L_k=-k, re only -> pair j matches the reference model over all 16 pairs, including floor rounding ((0+1)>>>1=0, (0-1)>>>1=-1).
- Back-to-back frames, valid_in at T and T+16 -> pulses at T+1 and T+17; 32 contiguous valid pairs T+2..T+33; outputs 0 at T+34. valid_in at T+5 -> ignored.
- Reset mid-frame at T+6 -> outputs 0 from that edge; no pulse or data until the next valid_in, which then behaves like the first scenario.
- Idle between frames -> all data outputs 0 and pulse low.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and sample types for the 32-point MDC FFT datapath.
// Samples are signed two's complement per re/im component.
package fft_pkg;
  localparam int DW          = 9;
  localparam int N           = 32;
  localparam int FRAME_PAIRS = N / 2;
  localparam int CNT_W       = $clog2(FRAME_PAIRS);

  typedef logic signed [DW-1:0] sample_t;

  typedef struct packed {
    sample_t re;
    sample_t im;
  } cplx_t;
endpackage

// File: rtl/bfly2_scale.sv
// Scaled radix-2 butterfly: sum=(a+b)>>>1, diff=(a-b)>>>1 per component.
// Combinational, no backpressure; the one-bit growth is absorbed by the floor shift.
import fft_pkg::*;

module bfly2_scale (
  input  cplx_t a,
  input  cplx_t b,
  output cplx_t sum,
  output cplx_t diff
);
  logic signed [DW:0] s_re, s_im, d_re, d_im;

  assign s_re = (DW+1)'(a.re) + (DW+1)'(b.re);
  assign s_im = (DW+1)'(a.im) + (DW+1)'(b.im);
  assign d_re = (DW+1)'(a.re) - (DW+1)'(b.re);
  assign d_im = (DW+1)'(a.im) - (DW+1)'(b.im);

  assign sum.re  = sample_t'(s_re >>> 1);
  assign sum.im  = sample_t'(s_im >>> 1);
  assign diff.re = sample_t'(d_re >>> 1);
  assign diff.im = sample_t'(d_im >>> 1);
endmodule

// File: rtl/mdc_stage5.sv
// Last MDC FFT stage: distance-1 W^0 butterflies on both lanes, serialised one pair/cycle.
// Latency 2 cycles first input to first output; no backpressure, frames are accepted unconditionally.
import fft_pkg::*;

module mdc_stage5 (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    valid_in,
  input  sample_t state4_outUp_re,
  input  sample_t state4_outUp_im,
  input  sample_t state4_outL_re,
  input  sample_t state4_outL_im,
  output logic    valid_ping_pong_in,
  output sample_t state5_outUp_re,
  output sample_t state5_outUp_im,
  output sample_t state5_outL_re,
  output sample_t state5_outL_im
);
  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PAIRS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start, active, odd;

  cplx_t u_in, l_in, u_hold, l_hold;
  cplx_t u_sum, u_diff, l_sum, l_diff;
  cplx_t skid_sum, skid_diff, out_up, out_l;
  logic  skid_vld, pp_q;

  assign u_in = '{re: state4_outUp_re, im: state4_outUp_im};
  assign l_in = '{re: state4_outL_re,  im: state4_outL_im};

  // cnt_q holds the index of the pair seen in the previous cycle; the current pair is cnt_q+1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    active  = 1'b0;
    odd     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          start   = 1'b1;
          active  = 1'b1;
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (valid_in) begin
            start  = 1'b1;
            active = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          active = 1'b1;
          odd    = ~cnt_q[0];
          cnt_d  = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  bfly2_scale u_bfly_up (.a(u_hold), .b(u_in), .sum(u_sum), .diff(u_diff));
  bfly2_scale u_bfly_l  (.a(l_hold), .b(l_in), .sum(l_sum), .diff(l_diff));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      u_hold    <= '0;
      l_hold    <= '0;
      skid_sum  <= '0;
      skid_diff <= '0;
      skid_vld  <= 1'b0;
      out_up    <= '0;
      out_l     <= '0;
      pp_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pp_q     <= start;
      skid_vld <= active && odd;
      if (active && !odd) begin
        u_hold <= u_in;
        l_hold <= l_in;
      end
      // Odd pairs emit the U butterfly now and park the L butterfly for the next cycle.
      if (active && odd) begin
        out_up    <= u_sum;
        out_l     <= u_diff;
        skid_sum  <= l_sum;
        skid_diff <= l_diff;
      end else if (skid_vld) begin
        out_up <= skid_sum;
        out_l  <= skid_diff;
      end else begin
        out_up <= '0;
        out_l  <= '0;
      end
    end
  end

  assign valid_ping_pong_in = pp_q;
  assign state5_outUp_re    = out_up.re;
  assign state5_outUp_im    = out_up.im;
  assign state5_outL_re     = out_l.re;
  assign state5_outL_im     = out_l.im;
endmodule

// File: tb/tb_mdc_stage5.sv
// Bench for mdc_stage5: directed vector table plus randomized frames checked against a
// cycle-indexed expectation table built from frame-level butterfly arithmetic.
module tb_mdc_stage5;
  import fft_pkg::*;

  localparam int MAXC = 4096;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  logic    valid_in = 1'b0;
  sample_t up_re = '0, up_im = '0, l_re = '0, l_im = '0;
  logic    pp;
  sample_t o_up_re, o_up_im, o_l_re, o_l_im;

  mdc_stage5 dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .state4_outUp_re(up_re), .state4_outUp_im(up_im),
    .state4_outL_re(l_re), .state4_outL_im(l_im),
    .valid_ping_pong_in(pp),
    .state5_outUp_re(o_up_re), .state5_outUp_im(o_up_im),
    .state5_outL_re(o_l_re), .state5_outL_im(o_l_im)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ure; int uim; int lre; int lim; int pp;
  } obs_t;

  typedef struct {
    int inp[8];  // u0re u0im u1re u1im l0re l0im l1re l1im
    int ex[8];   // pair0 {up re, up im, l re, l im}, pair1 {same}
  } vec_t;

  obs_t exp_q [MAXC];
  obs_t last;
  int   cyc = 0, tests = 0, fails = 0;
  bit   fr_active = 0;
  int   fr_start = 0;
  int   fu_re[16], fu_im[16], fl_re[16], fl_im[16];
  vec_t tbl[5];

  function automatic int half_floor(int x);
    return (x >= 0) ? x / 2 : -((1 - x) / 2);
  endfunction

  task automatic check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // One clock: sample outputs of the new cycle, compare with the model, drive this cycle's inputs.
  task automatic step(bit r, bit v, int ure, int uim, int lre, int lim);
    obs_t e;
    int   k;
    @(posedge clk);
    #1;
    cyc++;
    last.pp  = int'(pp);
    last.ure = int'(o_up_re);
    last.uim = int'(o_up_im);
    last.lre = int'(o_l_re);
    last.lim = int'(o_l_im);
    e = exp_q[cyc];
    tests++;
    if (last != e) begin
      fails++;
      $display("FAIL stream cycle %0d: got pp=%0d up=(%0d,%0d) l=(%0d,%0d), expected pp=%0d up=(%0d,%0d) l=(%0d,%0d)",
               cyc, last.pp, last.ure, last.uim, last.lre, last.lim, e.pp, e.ure, e.uim, e.lre, e.lim);
    end
    rst_n    = r;
    valid_in = v;
    up_re = sample_t'(ure);
    up_im = sample_t'(uim);
    l_re  = sample_t'(lre);
    l_im  = sample_t'(lim);
    if (!r) begin
      fr_active = 0;
      for (int i = cyc + 1; i < MAXC; i++) exp_q[i] = '{default: 0};
    end else begin
      if (v && (!fr_active || cyc - fr_start >= 16)) begin
        fr_active = 1;
        fr_start  = cyc;
        exp_q[cyc + 1].pp = 1;
      end
      if (fr_active && cyc - fr_start < 16) begin
        k = cyc - fr_start;
        fu_re[k] = ure; fu_im[k] = uim; fl_re[k] = lre; fl_im[k] = lim;
        if (k % 2 == 1) begin
          exp_q[fr_start + 1 + k].ure = half_floor(fu_re[k-1] + fu_re[k]);
          exp_q[fr_start + 1 + k].uim = half_floor(fu_im[k-1] + fu_im[k]);
          exp_q[fr_start + 1 + k].lre = half_floor(fu_re[k-1] - fu_re[k]);
          exp_q[fr_start + 1 + k].lim = half_floor(fu_im[k-1] - fu_im[k]);
          exp_q[fr_start + 2 + k].ure = half_floor(fl_re[k-1] + fl_re[k]);
          exp_q[fr_start + 2 + k].uim = half_floor(fl_im[k-1] + fl_im[k]);
          exp_q[fr_start + 2 + k].lre = half_floor(fl_re[k-1] - fl_re[k]);
          exp_q[fr_start + 2 + k].lim = half_floor(fl_im[k-1] - fl_im[k]);
        end
      end
    end
  endtask

  task automatic run_vec(int idx);
    vec_t t;
    t = tbl[idx];
    step(1, 1, t.inp[0], t.inp[1], t.inp[4], t.inp[5]);
    step(1, 0, t.inp[2], t.inp[3], t.inp[6], t.inp[7]);
    check($sformatf("v%0d_pulse", idx), last.pp, 1);
    step(1, 0, 0, 0, 0, 0);
    check($sformatf("v%0d_p0_up_re", idx), last.ure, t.ex[0]);
    check($sformatf("v%0d_p0_up_im", idx), last.uim, t.ex[1]);
    check($sformatf("v%0d_p0_l_re", idx),  last.lre, t.ex[2]);
    check($sformatf("v%0d_p0_l_im", idx),  last.lim, t.ex[3]);
    step(1, 0, 0, 0, 0, 0);
    check($sformatf("v%0d_p1_up_re", idx), last.ure, t.ex[4]);
    check($sformatf("v%0d_p1_up_im", idx), last.uim, t.ex[5]);
    check($sformatf("v%0d_p1_l_re", idx),  last.lre, t.ex[6]);
    check($sformatf("v%0d_p1_l_im", idx),  last.lim, t.ex[7]);
    for (int i = 4; i < 16 + 4; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  function automatic int rnd_s();
    return int'($urandom_range(0, 511)) - 256;
  endfunction

  initial begin
    for (int i = 0; i < MAXC; i++) exp_q[i] = '{default: 0};
    tbl[0] = '{inp: '{100, 0, 20, 0, 0, 0, 0, 0},         ex: '{60, 0, 40, 0, 0, 0, 0, 0}};
    tbl[1] = '{inp: '{0, 0, 0, 0, 255, 255, -256, -256},   ex: '{0, 0, 0, 0, -1, -1, 255, 255}};
    tbl[2] = '{inp: '{0, 0, 0, 0, -256, -256, 255, 255},   ex: '{0, 0, 0, 0, -1, -1, -256, -256}};
    tbl[3] = '{inp: '{-256, 255, -256, 255, 0, 0, 1, 0},   ex: '{-256, 255, 0, 0, 0, 0, -1, 0}};
    tbl[4] = '{inp: '{0, 3, 1, -2, -3, 7, -4, -8},         ex: '{0, 0, -1, 2, -4, -1, 0, 7}};

    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 5; i++) run_vec(i);

    // Ramp exercises floor rounding on every pair.
    for (int k = 0; k < 16; k++) step(1, k == 0, k, 0, -k, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);

    // Back-to-back frames with a stray valid_in inside the first.
    for (int i = 0; i < 32; i++)
      step(1, (i == 0) || (i == 5) || (i == 16), rnd_s(), rnd_s(), rnd_s(), rnd_s());
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);

    // Reset six cycles into a frame, then a clean frame afterwards.
    for (int i = 0; i < 6; i++) step(1, i == 0, rnd_s(), rnd_s(), rnd_s(), rnd_s());
    step(0, 0, rnd_s(), rnd_s(), rnd_s(), rnd_s());
    for (int i = 0; i < 5; i++) step(1, 0, rnd_s(), rnd_s(), rnd_s(), rnd_s());
    run_vec(0);

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 149) != 0, $urandom_range(0, 11) == 0,
           rnd_s(), rnd_s(), rnd_s(), rnd_s());
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
